// File: rtl/jtag_ir_ctrl_if.sv
// TAP-side bundle for the instruction register: state strobes and serial data in,
// retimed TDO and the latched instruction out.
interface jtag_ir_ctrl_if #(
  parameter int IR_WIDTH  = 4,
  parameter int NUM_INSTR = 4
);
  // A zero-width status field cannot exist, so the 2-bit IR keeps a dummy bit.
  localparam int ST_W = (IR_WIDTH > 2) ? IR_WIDTH - 2 : 1;

  logic                 tdi;
  logic                 capture_ir;
  logic                 shift_ir;
  logic                 update_ir;
  logic [ST_W-1:0]      capture_status;
  logic                 tdo;
  logic                 tdo_en;
  logic [NUM_INSTR-1:0] instructions;
  logic [IR_WIDTH-1:0]  ir_opcode;
  logic                 ir_hit;

  modport master (
    output tdi, capture_ir, shift_ir, update_ir, capture_status,
    input  tdo, tdo_en, instructions, ir_opcode, ir_hit
  );

  modport slave (
    input  tdi, capture_ir, shift_ir, update_ir, capture_status,
    output tdo, tdo_en, instructions, ir_opcode, ir_hit
  );
endinterface

// File: rtl/jtag_ir_ctrl.sv
// IEEE 1149.1 instruction register: capture/shift path on posedge tck, table-driven
// decoder with BYPASS fallback, update latch and TDO retime on negedge tck.
module jtag_ir_ctrl #(
  parameter int                            IR_WIDTH   = 4,
  parameter int                            NUM_INSTR  = 4,
  parameter logic [NUM_INSTR*IR_WIDTH-1:0] OPCODES    = {4'hF, 4'h2, 4'h0, 4'h1},
  parameter int                            RESET_IDX  = 0,
  parameter int                            BYPASS_IDX = 3
) (
  input  logic           tck,
  input  logic           tl_reset,
  jtag_ir_ctrl_if.slave  bus
);
  localparam int                   IDX_W       = $clog2(NUM_INSTR);
  localparam logic [IR_WIDTH-1:0]  RESET_OPC   = OPCODES[RESET_IDX*IR_WIDTH +: IR_WIDTH];
  localparam logic [NUM_INSTR-1:0] RESET_ONEHOT = NUM_INSTR'(1) << RESET_IDX;
  localparam logic [IR_WIDTH-1:0]  CAPTURE_RST = IR_WIDTH'(1);

  if (IR_WIDTH < 2) begin : g_chk_width
    $error("jtag_ir_ctrl: IR_WIDTH must be >= 2");
  end
  if (NUM_INSTR < 2) begin : g_chk_num
    $error("jtag_ir_ctrl: NUM_INSTR must be >= 2");
  end
  if (RESET_IDX >= NUM_INSTR || BYPASS_IDX >= NUM_INSTR) begin : g_chk_idx
    $error("jtag_ir_ctrl: RESET_IDX and BYPASS_IDX must be < NUM_INSTR");
  end else if (OPCODES[BYPASS_IDX*IR_WIDTH +: IR_WIDTH] != {IR_WIDTH{1'b1}}) begin : g_chk_bypass
    $error("jtag_ir_ctrl: BYPASS opcode table entry must be all-ones");
  end

  logic [IR_WIDTH-1:0]  r_sr;
  logic                 r_tdo;
  logic                 r_tdo_en;
  logic [IR_WIDTH-1:0]  r_opcode;
  logic [NUM_INSTR-1:0] r_instr;
  logic                 r_hit;

  logic [IR_WIDTH-1:0]  w_capture;
  logic [NUM_INSTR-1:0] w_eq;
  logic [IDX_W-1:0]     w_idx;
  logic                 w_hit;
  logic [NUM_INSTR-1:0] w_onehot;

  // Fixed 01 in the two LSBs lets the board detect a broken IR chain.
  if (IR_WIDTH > 2) begin : g_cap_status
    assign w_capture = {bus.capture_status, 2'b01};
  end else begin : g_cap_fixed
    logic w_unused_status;
    assign w_unused_status = ^bus.capture_status;
    assign w_capture       = 2'b01;
  end

  for (genvar gi = 0; gi < NUM_INSTR; gi++) begin : g_match
    assign w_eq[gi] = (OPCODES[gi*IR_WIDTH +: IR_WIDTH] == r_sr);
  end

  // Scanning from the top down leaves the lowest matching index as the winner.
  always_comb begin
    w_idx = IDX_W'(BYPASS_IDX);
    w_hit = 1'b0;
    for (int i = NUM_INSTR - 1; i >= 0; i--) begin
      if (w_eq[i]) begin
        w_idx = IDX_W'(i);
        w_hit = 1'b1;
      end
    end
  end

  assign w_onehot = NUM_INSTR'(1) << w_idx;

  always_ff @(posedge tck or posedge tl_reset) begin
    if (tl_reset) begin
      r_sr <= CAPTURE_RST;
    end else if (bus.capture_ir) begin
      r_sr <= w_capture;
    end else if (bus.shift_ir) begin
      r_sr <= {bus.tdi, r_sr[IR_WIDTH-1:1]};
    end
  end

  always_ff @(negedge tck or posedge tl_reset) begin
    if (tl_reset) begin
      r_tdo    <= 1'b0;
      r_tdo_en <= 1'b0;
    end else begin
      r_tdo_en <= bus.shift_ir;
      if (bus.shift_ir) begin
        r_tdo <= r_sr[0];
      end
    end
  end

  always_ff @(negedge tck or posedge tl_reset) begin
    if (tl_reset) begin
      r_opcode <= RESET_OPC;
      r_instr  <= RESET_ONEHOT;
      r_hit    <= 1'b1;
    end else if (bus.update_ir) begin
      r_opcode <= r_sr;
      r_instr  <= w_onehot;
      r_hit    <= w_hit;
    end
  end

  assign bus.tdo          = r_tdo;
  assign bus.tdo_en       = r_tdo_en;
  assign bus.ir_opcode    = r_opcode;
  assign bus.instructions = r_instr;
  assign bus.ir_hit       = r_hit;
endmodule

// File: tb/tb_jtag_ir_ctrl.sv
// Directed bench for jtag_ir_ctrl: default 4-bit IR plus a 2-bit IR build driven in
// lockstep from the same TAP strobes.
module tb_jtag_ir_ctrl;
  logic tck = 1'b0;
  logic tl_reset;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 tck = ~tck;

  jtag_ir_ctrl_if #(.IR_WIDTH(4), .NUM_INSTR(4)) b1 ();
  jtag_ir_ctrl_if #(.IR_WIDTH(2), .NUM_INSTR(2)) b2 ();

  jtag_ir_ctrl dut (
    .tck      (tck),
    .tl_reset (tl_reset),
    .bus      (b1)
  );

  jtag_ir_ctrl #(
    .IR_WIDTH   (2),
    .NUM_INSTR  (2),
    .OPCODES    (4'b11_01),
    .RESET_IDX  (0),
    .BYPASS_IDX (1)
  ) dut2 (
    .tck      (tck),
    .tl_reset (tl_reset),
    .bus      (b2)
  );

  // Called at posedge+1: drives one TAP state for a full cycle, returns at the next posedge+1.
  task automatic step(input logic c, input logic s, input logic u, input logic d);
    b1.capture_ir = c; b1.shift_ir = s; b1.update_ir = u; b1.tdi = d;
    b2.capture_ir = c; b2.shift_ir = s; b2.update_ir = u; b2.tdi = d;
    @(negedge tck); #1;
    @(posedge tck); #1;
  endtask

  task automatic shift_in(input logic [3:0] v);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, v[i]);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    $display("update: opcode %h -> instructions=%b ir_hit=%b", v, b1.instructions, b1.ir_hit);
  endtask

  task automatic test_reset;
    tl_reset = 1'b1;
    b1.capture_status = 2'b10;
    b2.capture_status = 1'b0;
    b1.capture_ir = 0; b1.shift_ir = 0; b1.update_ir = 0; b1.tdi = 0;
    b2.capture_ir = 0; b2.shift_ir = 0; b2.update_ir = 0; b2.tdi = 0;
    #12;
    tl_reset = 1'b0;
    @(posedge tck); #1;
    n_cmp++; if (b1.instructions !== 4'b0001) begin n_bad++; $display("FAIL reset_instr: got %b expected 0001", b1.instructions); end
    n_cmp++; if (b1.ir_opcode !== 4'h1) begin n_bad++; $display("FAIL reset_opcode: got %h expected 1", b1.ir_opcode); end
    n_cmp++; if (b1.ir_hit !== 1'b1) begin n_bad++; $display("FAIL reset_hit: got %b expected 1", b1.ir_hit); end
    n_cmp++; if (b1.tdo_en !== 1'b0) begin n_bad++; $display("FAIL reset_tdo_en: got %b expected 0", b1.tdo_en); end
    n_cmp++; if (b1.tdo !== 1'b0) begin n_bad++; $display("FAIL reset_tdo: got %b expected 0", b1.tdo); end
    n_cmp++; if (b2.instructions !== 2'b01) begin n_bad++; $display("FAIL w2_reset_instr: got %b expected 01", b2.instructions); end
    n_cmp++; if (b2.ir_opcode !== 2'b01) begin n_bad++; $display("FAIL w2_reset_opcode: got %b expected 01", b2.ir_opcode); end
    $display("reset: instructions=%b opcode=%h hit=%b", b1.instructions, b1.ir_opcode, b1.ir_hit);
  endtask

  task automatic test_capture_shift;
    logic [3:0] exp_seq;
    exp_seq = 4'b1001;  // bit i = i-th TDO bit: 1,0,0,1
    step(1'b1, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (b1.tdo_en !== 1'b0) begin n_bad++; $display("FAIL capture_tdo_en: got %b expected 0", b1.tdo_en); end
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0);
      $display("shift bit %0d: tdo=%b tdo_en=%b", i, b1.tdo, b1.tdo_en);
      n_cmp++; if (b1.tdo !== exp_seq[i]) begin n_bad++; $display("FAIL shift_tdo[%0d]: got %b expected %b", i, b1.tdo, exp_seq[i]); end
      n_cmp++; if (b1.tdo_en !== 1'b1) begin n_bad++; $display("FAIL shift_tdo_en[%0d]: got %b expected 1", i, b1.tdo_en); end
    end
    n_cmp++; if (b1.instructions !== 4'b0001) begin n_bad++; $display("FAIL shift_instr_hold: got %b expected 0001", b1.instructions); end
    step(1'b0, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (b1.tdo !== 1'b1) begin n_bad++; $display("FAIL idle_tdo_hold: got %b expected 1", b1.tdo); end
    n_cmp++; if (b1.tdo_en !== 1'b0) begin n_bad++; $display("FAIL idle_tdo_en: got %b expected 0", b1.tdo_en); end
  endtask

  task automatic test_update;
    logic [3:0] v;
    shift_in(4'h2);
    n_cmp++; if (b1.instructions !== 4'b0100) begin n_bad++; $display("FAIL upd2_instr: got %b expected 0100", b1.instructions); end
    n_cmp++; if (b1.ir_opcode !== 4'h2) begin n_bad++; $display("FAIL upd2_opcode: got %h expected 2", b1.ir_opcode); end
    n_cmp++; if (b1.ir_hit !== 1'b1) begin n_bad++; $display("FAIL upd2_hit: got %b expected 1", b1.ir_hit); end
    v = 4'h7;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 1'b0, v[i]);
      n_cmp++; if (b1.instructions !== 4'b0100) begin n_bad++; $display("FAIL shift7_instr_hold[%0d]: got %b expected 0100", i, b1.instructions); end
    end
    step(1'b0, 1'b0, 1'b1, 1'b0);
    $display("update: opcode 7 -> instructions=%b ir_hit=%b", b1.instructions, b1.ir_hit);
    n_cmp++; if (b1.instructions !== 4'b1000) begin n_bad++; $display("FAIL upd7_instr: got %b expected 1000", b1.instructions); end
    n_cmp++; if (b1.ir_opcode !== 4'h7) begin n_bad++; $display("FAIL upd7_opcode: got %h expected 7", b1.ir_opcode); end
    n_cmp++; if (b1.ir_hit !== 1'b0) begin n_bad++; $display("FAIL upd7_hit: got %b expected 0", b1.ir_hit); end
    shift_in(4'hF);
    n_cmp++; if (b1.instructions !== 4'b1000) begin n_bad++; $display("FAIL updF_instr: got %b expected 1000", b1.instructions); end
    n_cmp++; if (b1.ir_opcode !== 4'hF) begin n_bad++; $display("FAIL updF_opcode: got %h expected F", b1.ir_opcode); end
    n_cmp++; if (b1.ir_hit !== 1'b1) begin n_bad++; $display("FAIL updF_hit: got %b expected 1", b1.ir_hit); end
  endtask

  task automatic test_reset_mid_shift;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);  // tdo now shows the captured 1
    #2 tl_reset = 1'b1;
    #1;
    $display("async reset mid-shift: instructions=%b tdo=%b", b1.instructions, b1.tdo);
    n_cmp++; if (b1.instructions !== 4'b0001) begin n_bad++; $display("FAIL rst_mid_instr: got %b expected 0001", b1.instructions); end
    n_cmp++; if (b1.ir_opcode !== 4'h1) begin n_bad++; $display("FAIL rst_mid_opcode: got %h expected 1", b1.ir_opcode); end
    n_cmp++; if (b1.tdo !== 1'b0) begin n_bad++; $display("FAIL rst_mid_tdo: got %b expected 0", b1.tdo); end
    n_cmp++; if (b1.tdo_en !== 1'b0) begin n_bad++; $display("FAIL rst_mid_tdo_en: got %b expected 0", b1.tdo_en); end
    b1.shift_ir = 1'b0; b2.shift_ir = 1'b0;
    tl_reset = 1'b0;
    @(posedge tck); #1;
    // Shifting without capture exposes the reset value of sr (0001) on tdo.
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0);
      n_cmp++; if (b1.tdo !== (i == 0)) begin n_bad++; $display("FAIL rst_sr_tdo[%0d]: got %b expected %b", i, b1.tdo, (i == 0)); end
    end
    step(1'b0, 1'b0, 1'b1, 1'b0);
    n_cmp++; if (b1.instructions !== 4'b0010) begin n_bad++; $display("FAIL upd0_instr: got %b expected 0010", b1.instructions); end
    n_cmp++; if (b2.instructions !== 2'b10) begin n_bad++; $display("FAIL w2_bypass_instr: got %b expected 10", b2.instructions); end
    n_cmp++; if (b2.ir_hit !== 1'b0) begin n_bad++; $display("FAIL w2_bypass_hit: got %b expected 0", b2.ir_hit); end
  endtask

  task automatic test_cap_shift_conflict;
    step(1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    $display("capture+shift: opcode=%h instructions=%b", b1.ir_opcode, b1.instructions);
    n_cmp++; if (b1.ir_opcode !== 4'h9) begin n_bad++; $display("FAIL conflict_opcode: got %h expected 9", b1.ir_opcode); end
    n_cmp++; if (b1.instructions !== 4'b1000) begin n_bad++; $display("FAIL conflict_instr: got %b expected 1000", b1.instructions); end
    n_cmp++; if (b1.ir_hit !== 1'b0) begin n_bad++; $display("FAIL conflict_hit: got %b expected 0", b1.ir_hit); end
    n_cmp++; if (b2.ir_opcode !== 2'b01) begin n_bad++; $display("FAIL w2_conflict_opcode: got %b expected 01", b2.ir_opcode); end
  endtask

  task automatic test_w2;
    shift_in(4'hC);  // 2-bit IR retains the last two bits shifted: 11
    n_cmp++; if (b2.instructions !== 2'b10) begin n_bad++; $display("FAIL w2_all1_instr: got %b expected 10", b2.instructions); end
    n_cmp++; if (b2.ir_hit !== 1'b1) begin n_bad++; $display("FAIL w2_all1_hit: got %b expected 1", b2.ir_hit); end
    n_cmp++; if (b2.ir_opcode !== 2'b11) begin n_bad++; $display("FAIL w2_all1_opcode: got %b expected 11", b2.ir_opcode); end
    n_cmp++; if (b1.instructions !== 4'b1000) begin n_bad++; $display("FAIL updC_instr: got %b expected 1000", b1.instructions); end
  endtask

  initial begin
    test_reset();
    test_capture_shift();
    test_update();
    test_reset_mid_shift();
    test_cap_shift_conflict();
    test_w2();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
